// File: rtl/nts_rx_dispatcher.sv
// Receive-side frame buffer: stores one MAC frame and presents it first-word-fall-through to a dispatcher.
// Optional drop counter: define NTS_RX_DISPATCHER_DROP_COUNTER_EN to add o_drop_count.

// state   | meaning
// IDLE    | waiting for the first word of a frame
// RECV    | storing words of the current frame
// DISCARD | dropping the rest of a frame until its last word
// HOLD    | one complete frame stored; incoming frames are dropped
module nts_rx_dispatcher #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic        i_clk,
   input  logic        i_areset,
   input  logic        i_mac_data_valid,
   input  logic [63:0] i_mac_data,
   input  logic        i_mac_last,
   input  logic        i_mac_bad_frame,
   output logic        o_dispatch_packet_available,
   input  logic        i_dispatch_packet_read,
   output logic        o_dispatch_fifo_empty,
   input  logic        i_dispatch_fifo_rd_en,
   output logic [63:0] o_dispatch_fifo_rd_data
`ifdef NTS_RX_DISPATCHER_DROP_COUNTER_EN
   ,
   output logic [31:0] o_drop_count
`endif
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RECV    = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;
   localparam logic [1:0] ST_HOLD    = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  mac_mid;
   logic [63:0]           mem [0:(1<<ADDR_WIDTH)-1];
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  frame_drop;
   logic                  in_hold;
   logic                  fifo_empty;

   assign in_hold    = (state == ST_HOLD);
   assign fifo_empty = !(in_hold && (rd_ptr <= {1'b0, wr_ptr}));

   // mac_mid marks the line as inside a frame, so a leftover tail is never taken as a new frame
   always_comb begin
      wr_en      = 1'b0;
      wr_addr    = wr_ptr;
      frame_drop = 1'b0;
      if (i_areset && i_mac_data_valid) begin
         case (state)
            ST_IDLE: begin
               if (!mac_mid) begin
                  wr_en      = 1'b1;
                  wr_addr    = '0;
                  frame_drop = i_mac_last && i_mac_bad_frame;
               end
            end
            ST_RECV: begin
               wr_en      = i_mac_last || (wr_ptr != PTR_MAX);
               frame_drop = i_mac_last ? i_mac_bad_frame : (wr_ptr == PTR_MAX);
            end
            ST_HOLD:  frame_drop = !mac_mid;
            default:  frame_drop = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_addr] <= i_mac_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_areset) begin
         state  <= ST_IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         // keep following the line so a frame spanning reset release is skipped
         if (i_mac_data_valid) mac_mid <= !i_mac_last;
      end else begin
         if (i_mac_data_valid) mac_mid <= !i_mac_last;
         case (state)
            ST_IDLE: begin
               if (i_mac_data_valid) begin
                  if (mac_mid) begin
                     if (!i_mac_last) state <= ST_DISCARD;
                  end else if (i_mac_last) begin
                     state <= i_mac_bad_frame ? ST_IDLE : ST_HOLD;
                  end else begin
                     state  <= ST_RECV;
                     wr_ptr <= ADDR_WIDTH'(1);
                  end
               end
            end
            ST_RECV: begin
               if (i_mac_data_valid) begin
                  if (i_mac_last) begin
                     if (i_mac_bad_frame) begin
                        state  <= ST_IDLE;
                        wr_ptr <= '0;
                     end else begin
                        state <= ST_HOLD;
                     end
                  end else if (wr_ptr == PTR_MAX) begin
                     state  <= ST_DISCARD;
                     wr_ptr <= '0;
                  end else begin
                     wr_ptr <= wr_ptr + 1'b1;
                  end
               end
            end
            ST_DISCARD: begin
               if (i_mac_data_valid && i_mac_last) state <= ST_IDLE;
            end
            default: begin
               if (i_dispatch_packet_read) begin
                  state  <= ST_IDLE;
                  wr_ptr <= '0;
                  rd_ptr <= '0;
               end else if (i_dispatch_fifo_rd_en && !fifo_empty) begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
            end
         endcase
      end
   end

   assign o_dispatch_packet_available = in_hold;
   assign o_dispatch_fifo_empty       = fifo_empty;
   assign o_dispatch_fifo_rd_data     = in_hold ? mem[rd_ptr[ADDR_WIDTH-1:0]] : 64'd0;

`ifdef NTS_RX_DISPATCHER_DROP_COUNTER_EN
   logic [31:0] drop_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_areset) begin
         drop_cnt <= '0;
      end else if (frame_drop && (drop_cnt != 32'hFFFF_FFFF)) begin
         drop_cnt <= drop_cnt + 32'd1;
      end
   end

   assign o_drop_count = drop_cnt;
`else
   logic unused_drop;
   assign unused_drop = frame_drop;
`endif

endmodule

// File: doc/nts_rx_dispatcher.md
NTS_RX_DISPATCHER -- requirements
Module: nts_rx_dispatcher

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving a packet store depth of 2^ADDR_WIDTH 64-bit words.
REQ-002 The block SHALL have port i_clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port i_areset, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port i_mac_data_valid, input, 1, qualifies i_mac_data this cycle.
REQ-005 The block SHALL have port i_mac_data, input, 64, frame word, first byte in bits 63:56.
REQ-006 The block SHALL have port i_mac_last, input, 1, marks the final word of the frame; valid only with i_mac_data_valid.
REQ-007 The block SHALL have port i_mac_bad_frame, input, 1, sampled with i_mac_last; high means discard the frame.
REQ-008 The block SHALL have port o_dispatch_packet_available, output, 1, a complete frame is stored.
REQ-009 The block SHALL have port i_dispatch_packet_read, input, 1, one-cycle pulse from the consumer releasing the frame.
REQ-010 The block SHALL have port o_dispatch_fifo_empty, output, 1, no unread words remain.
REQ-011 The block SHALL have port i_dispatch_fifo_rd_en, input, 1, consumer pops the current word.
REQ-012 The block SHALL have port o_dispatch_fifo_rd_data, output, 64, current head word.

Function
REQ-013 The FSM SHALL have states IDLE, RECV, DISCARD and HOLD.
REQ-014 In IDLE, a cycle with i_mac_data_valid SHALL write the word at address 0 and go to RECV, or go to HOLD if i_mac_last is also high.
REQ-015 In RECV, each valid word SHALL be written at wr_ptr and wr_ptr SHALL increment; on i_mac_last the FSM SHALL go to HOLD.
REQ-016 In RECV, a valid non-last word arriving with wr_ptr = 2^ADDR_WIDTH-1 SHALL set overflow and move the FSM to DISCARD; a last word in that slot SHALL be accepted.
REQ-017 i_mac_bad_frame high with i_mac_last SHALL return the FSM to IDLE with wr_ptr cleared; no availability is signalled.
REQ-018 In DISCARD, words SHALL be ignored until the valid cycle with i_mac_last, after which the FSM SHALL go to IDLE.
REQ-019 In HOLD, o_dispatch_packet_available SHALL be 1, the stored length SHALL be wr_ptr+1 words, and frames arriving SHALL be dropped whole, as in DISCARD, with the FSM returning to HOLD.
REQ-020 Read side SHALL be first-word-fall-through: in HOLD, o_dispatch_fifo_rd_data SHALL equal word rd_ptr and o_dispatch_fifo_empty SHALL be 0 while rd_ptr < length.
REQ-021 i_dispatch_fifo_rd_en high while not empty SHALL advance rd_ptr, and the next word SHALL appear on the following cycle; rd_en while empty SHALL be ignored.
REQ-022 After the last word is popped, o_dispatch_fifo_empty SHALL be 1 from the next cycle.
REQ-023 i_dispatch_packet_read in HOLD SHALL clear availability, clear rd_ptr and wr_ptr, and return the FSM to IDLE on the next cycle, whether or not all words were read.
REQ-024 If i_dispatch_packet_read coincides with a valid MAC word, that word SHALL be treated as mid-frame of a dropped frame.
REQ-025 Outside HOLD, o_dispatch_fifo_empty SHALL be 1 and o_dispatch_packet_available SHALL be 0.

Reset
REQ-026 i_areset low at a rising edge SHALL force IDLE, clear all pointers and flags, and set o_dispatch_packet_available=0, o_dispatch_fifo_empty=1 and o_dispatch_fifo_rd_data=0; memory contents are not reset.
REQ-027 Reset asserted mid-frame or in HOLD SHALL abandon the frame, and a MAC frame in progress when reset releases SHALL be ignored until its i_mac_last.

Configuration
REQ-028 With NTS_RX_DISPATCHER_DROP_COUNTER_EN defined, the block SHALL add output o_drop_count, 32 bits, incremented once per dropped frame (bad, overflow, or arrived during HOLD), saturating at all-ones and cleared by reset.
REQ-029 Without NTS_RX_DISPATCHER_DROP_COUNTER_EN, the port and counter SHALL be absent and behaviour is otherwise identical.

Verification
REQ-030 Three-word frame DEADBEEF00000000, ABAD1DEAC0FEF00D, 0123456789ABCDEF with last on word 3 -> available=1 next cycle, rd_data=DEADBEEF00000000, and three rd_en pops return the words in order, then empty=1.
REQ-031 After REQ-030, pulse packet_read -> available=0 and empty=1 next cycle; a new one-word frame 1111111111111111 -> available=1 and rd_data=1111111111111111.
REQ-032 Frame ending with i_mac_bad_frame=1 -> available stays 0 and drop_count=1 (macro defined).
REQ-033 ADDR_WIDTH=2 with a 5-word frame -> dropped, available=0; a following 4-word frame -> accepted.
REQ-034 Second frame sent during HOLD -> first frame is read back intact and drop_count increments by 1.
REQ-035 Reset asserted mid-read with rd_ptr=1 -> available=0, empty=1, rd_data=0 on the next cycle.
